output_display: RTL and testbench
=================================

# output_display

Parametrised output stage for the 8-bit CPU, replacing the raw LED bus tap. It captures a value from the CPU bus when the control unit asserts the output-enable strobe, and converts it to decimal with a sequential double-dabble engine, optionally as a signed value. It then drives a time-multiplexed, active-low seven-segment display. All logic runs on the CPU clock domain.

## Interface
- DATA_WIDTH, 8: width of the captured bus value.
- DIGITS, 4: number of display digits. Static check: it must satisfy DIGITS ≥ decimal digits of (2^DATA_WIDTH − 1), plus 1 for the sign digit; otherwise an elaboration error is raised.
- SCAN_DIV, 1024: number of clk cycles each digit is held; minimum 1.
- clk  in  1  CPU clock; everything samples on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- load  in  1  capture strobe (driven by control out_en).
- bus  in  DATA_WIDTH  CPU bus value, sampled when load=1.
- signed_mode  in  1  1 = display as two's complement; sampled with load.
- value  out  DATA_WIDTH  captured output register.
- busy  out  1  conversion in progress.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dig  out  DIGITS  digit enables, active-low, one-hot; bit 0 = least significant digit.

## Operation
- Reset values:
  - value=0, busy=0, state IDLE.
  - The display register holds "0": digit 0 = 0, all other digits blank.
  - Scan counter = 0, digit index = 0, dig=~1, seg=7'b1000000.
- FSM states:
  - IDLE → SHIFT on load.
  - SHIFT → IDLE after exactly DATA_WIDTH iterations.
- On load (in any state):
  - value ← bus.
  - Latch the sign flag: signed_mode & bus[MSB].
  - Load the shift register with the magnitude: −bus if the sign flag is set, else bus. −(2^(DATA_WIDTH−1)) converts correctly as an unsigned magnitude.
  - Clear the BCD accumulator and set iteration count = 0; state ← SHIFT.
- Each SHIFT cycle performs one double-dabble step:
  - Every BCD nibble ≥ 5 gets +3.
  - Then {bcd, shift} is shifted left by 1.
- After the last iteration, latch the display register from the BCD result and sign flag; state ← IDLE.
- Display register formatting:
  - Leading zeros are blanked; value 0 shows a single "0".
  - If the sign flag is set, the most significant digit (DIGITS−1) shows '-' (7'b0111111).
- load during SHIFT: the conversion restarts with the new value. The old conversion is discarded. The display keeps its previous contents until the new result latches.
- Scan: a counter counts 0..SCAN_DIV−1.
  - On terminal count it wraps to 0 and the digit index advances, wrapping DIGITS−1 → 0.
  - seg is the decode of the display register digit at the current index. Blank = 7'b1111111.
  - Scanning is independent of load/busy.

## Timing
- load sampled at edge 0 → value valid after edge 0; busy=1 from edge 0 to edge DATA_WIDTH.
- Display register updated at edge DATA_WIDTH; busy=0 after edge DATA_WIDTH.
- seg/dig are registered and change one cycle after the scan-counter terminal count.
- Each digit is active for exactly SCAN_DIV cycles; the full frame is DIGITS×SCAN_DIV cycles.
- rst asserted at any time: all registers take reset values immediately, including a mid-conversion reset. No partial result is ever displayed.

## Configuration
- OUTPUT_DISPLAY_HEX_EN defined:
  - Adds input hex_mode (1 bit), sampled with load.
  - When hex_mode=1, the display register ← raw nibbles of bus at the load edge. Digits above ceil(DATA_WIDTH/4) are blank; no sign, no conversion, busy stays 0.
  - A hex load during SHIFT aborts the conversion.
- Undefined: no hex_mode port; decimal only.

## Test plan
- Reset (DATA_WIDTH=8, DIGITS=4, SCAN_DIV=4) → value=0, busy=0, dig=4'b1110, seg=7'b1000000.
- Scan: hold idle for 20 clks → dig sequence 1110, 1101, 1011, 0111, 1110, each held 4 clks; digits 1–3 blank (7'b1111111).
- load bus=0xFF, signed_mode=0 → busy high exactly 8 cycles. Display then reads digit2=2 (7'b0100100), digit1=5 (7'b0010010), digit0=5, digit3 blank.
- load bus=0x80, signed_mode=1 → display "-128": digit3=7'b0111111, digit2=1, digit1=2, digit0=8; value=0x80.
- load 0x2A, then load 0x07 on the 3rd busy cycle → busy falls 8 cycles after the second load. The display goes from the previous contents directly to "7"; "42" never appears.
- With OUTPUT_DISPLAY_HEX_EN: hex_mode=1, load 0xA5 → busy stays 0; digit1=A (7'b0001000), digit0=5; digits 2–3 blank.

Source files
------------

// File: rtl/output_display.sv
// output_display: captures a CPU bus value on load, converts it to decimal
// (optionally signed) with a sequential double-dabble engine, and drives a
// time-multiplexed active-low seven-segment display.
// Optional feature macro: OUTPUT_DISPLAY_HEX_EN adds hex_mode (raw hex display).
module output_display #(
  parameter int DATA_WIDTH = 8,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] bus,
  input  logic                  signed_mode,
`ifdef OUTPUT_DISPLAY_HEX_EN
  input  logic                  hex_mode,
`endif
  output logic [DATA_WIDTH-1:0] value,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig
);

  // Number of decimal digits needed for (2^w - 1).
  function automatic int dec_digits(input int w);
    longint unsigned m;
    int n;
    m = (64'd1 << w) - 64'd1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (m != 64'd0) begin
        m = m / 64'd10;
        n = n + 1;
      end else begin
        m = m;
      end
    end
    if (n == 0) begin
      n = 1;
    end else begin
      n = n;
    end
    return n;
  endfunction

  localparam int NBCD = dec_digits(DATA_WIDTH);
  localparam int BW   = 4 * NBCD;
  localparam int NHEX = (DATA_WIDTH + 3) / 4;
  localparam int IW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int XW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Display digit codes: 0..15 are hex/decimal values, plus blank and minus.
  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_MINUS = 5'd17;

  typedef logic [DIGITS-1:0][4:0] disp_t;
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  generate
    if (DIGITS < NBCD + 1) begin : g_digits_check
      $error("output_display: DIGITS too small for DATA_WIDTH plus sign digit");
    end
    if (SCAN_DIV < 1) begin : g_scan_check
      $error("output_display: SCAN_DIV must be at least 1");
    end
    if (DATA_WIDTH < 2 || DATA_WIDTH > 63) begin : g_width_check
      $error("output_display: DATA_WIDTH must be in 2..63");
    end
  endgenerate

  // Display contents after reset: a single "0" in the least significant digit.
  function automatic disp_t reset_disp();
    disp_t d;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = CODE_BLANK;
    end
    d[0] = 5'd0;
    return d;
  endfunction

  // Leading-zero-blanked decimal formatting with optional '-' in the top digit.
  function automatic disp_t format_dec(input logic [BW-1:0] b, input logic s);
    disp_t d;
    logic  nz;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = CODE_BLANK;
    end
    nz = 1'b0;
    for (int i = NBCD - 1; i >= 0; i--) begin
      if (b[4*i +: 4] != 4'd0) begin
        nz = 1'b1;
      end else begin
        nz = nz;
      end
      if (nz || (i == 0)) begin
        d[i] = {1'b0, b[4*i +: 4]};
      end else begin
        d[i] = CODE_BLANK;
      end
    end
    if (s) begin
      d[DIGITS-1] = CODE_MINUS;
    end else begin
      d[DIGITS-1] = d[DIGITS-1];
    end
    return d;
  endfunction

`ifdef OUTPUT_DISPLAY_HEX_EN
  // Raw nibble formatting; digits above the bus width are blank.
  function automatic disp_t format_hex(input logic [DATA_WIDTH-1:0] b);
    disp_t d;
    logic [4*NHEX-1:0] p;
    p = (4*NHEX)'(b);
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = CODE_BLANK;
    end
    for (int i = 0; i < NHEX; i++) begin
      d[i] = {1'b0, p[4*i +: 4]};
    end
    return d;
  endfunction
`endif

  // Active-low segment decode, ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b0000011;
      5'd12:   s = 7'b1000110;
      5'd13:   s = 7'b0100001;
      5'd14:   s = 7'b0000110;
      5'd15:   s = 7'b0001110;
      5'd17:   s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  state_t                state, state_next;
  logic                  sign_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [BW-1:0]         bcd_r;
  logic [IW-1:0]         iter_r;
  disp_t                 disp_r;
  logic                  busy_r;
  logic [CW-1:0]         cnt_r;
  logic [XW-1:0]         idx_r;
  logic [6:0]            seg_r;
  logic [DIGITS-1:0]     dig_r;

  logic                  load_dec;
  logic                  load_hex;
  logic                  sign_in;
  logic [DATA_WIDTH-1:0] mag;
  logic                  last;
  logic [BW-1:0]         bcd_adj;
  logic [BW-1:0]         bcd_step;
  logic [DATA_WIDTH-1:0] shift_step;

`ifdef OUTPUT_DISPLAY_HEX_EN
  assign load_dec = load & ~hex_mode;
  assign load_hex = load & hex_mode;
`else
  assign load_dec = load;
  assign load_hex = 1'b0;
`endif

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign sign_in = signed_mode & bus[DATA_WIDTH-1];
  assign mag     = sign_in ? (~bus + DATA_WIDTH'(1)) : bus;
  assign last    = (iter_r == IW'(DATA_WIDTH - 1));

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, shift} left.
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
    bcd_step   = {bcd_adj[BW-2:0], shift_r[DATA_WIDTH-1]};
    shift_step = {shift_r[DATA_WIDTH-2:0], 1'b0};
  end

  // Next-state logic: a decimal load always (re)starts a conversion, a hex load aborts it.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (load_dec) begin
          state_next = S_SHIFT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (load_dec) begin
          state_next = S_SHIFT;
        end else if (load_hex || last) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_SHIFT;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
    end else begin
      state  <= state_next;
      busy_r <= (state_next == S_SHIFT);
    end
  end

  // Capture, conversion datapath and display register; display changes only on a complete result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value   <= '0;
      sign_r  <= 1'b0;
      shift_r <= '0;
      bcd_r   <= '0;
      iter_r  <= '0;
      disp_r  <= reset_disp();
    end else if (load_dec) begin
      value   <= bus;
      sign_r  <= sign_in;
      shift_r <= mag;
      bcd_r   <= '0;
      iter_r  <= '0;
`ifdef OUTPUT_DISPLAY_HEX_EN
    end else if (load_hex) begin
      value  <= bus;
      disp_r <= format_hex(bus);
`endif
    end else if (state == S_SHIFT) begin
      bcd_r   <= bcd_step;
      shift_r <= shift_step;
      iter_r  <= iter_r + IW'(1);
      if (last) begin
        disp_r <= format_dec(bcd_step, sign_r);
      end else begin
        disp_r <= disp_r;
      end
    end else begin
      value <= value;
    end
  end

  // Scan counter and digit index; the index advances on the counter's terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (cnt_r == CW'(SCAN_DIV - 1)) begin
      cnt_r <= '0;
      if (idx_r == XW'(DIGITS - 1)) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + XW'(1);
      end
    end else begin
      cnt_r <= cnt_r + CW'(1);
      idx_r <= idx_r;
    end
  end

  // Registered segment and digit-enable drive for the current digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= 7'b1000000;
      dig_r <= ~DIGITS'(1);
    end else begin
      seg_r <= seg_decode(disp_r[idx_r]);
      dig_r <= ~(DIGITS'(1) << idx_r);
    end
  end

  assign busy = busy_r;
  assign seg  = seg_r;
  assign dig  = dig_r;

endmodule

// File: tb/tb_output_display.sv
// Directed self-checking bench for output_display (DATA_WIDTH=8, DIGITS=4, SCAN_DIV=4).
module tb_output_display;

  localparam int DW = 8;
  localparam int ND = 4;
  localparam int SD = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SM = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [DW-1:0] bus;
  logic          signed_mode;
`ifdef OUTPUT_DISPLAY_HEX_EN
  logic          hex_mode;
`endif
  logic [DW-1:0] value;
  logic          busy;
  logic [6:0]    seg;
  logic [ND-1:0] dig;

  int n_checks = 0;
  int n_pass   = 0;
  int seen4    = 0;
  logic watch  = 1'b0;

  output_display #(.DATA_WIDTH(DW), .DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .bus(bus),
    .signed_mode(signed_mode),
`ifdef OUTPUT_DISPLAY_HEX_EN
    .hex_mode(hex_mode),
`endif
    .value(value),
    .busy(busy),
    .seg(seg),
    .dig(dig)
  );

  always #5 clk = ~clk;

  // Count any appearance of the digit '4' while a restart is being observed.
  always @(negedge clk) begin
    if (watch && seg == S4) seen4++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_load(input logic [DW-1:0] b, input logic sm);
    @(negedge clk);
    load = 1'b1;
    bus = b;
    signed_mode = sm;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called right after do_load: counts negedge samples with busy high.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_digit(input int i, input logic [6:0] exp, input string tag);
    logic [ND-1:0] want;
    bit found;
    want = ~(ND'(1) << i);
    found = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (dig == want) begin
        found = 1;
        break;
      end
    end
    if (found) check($sformatf("%s_d%0d", tag, i), {25'd0, seg}, {25'd0, exp});
    else check($sformatf("%s_d%0d_timeout", tag, i), 32'd0, 32'd1);
  endtask

  task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0);
    read_digit(0, e0, tag);
    read_digit(1, e1, tag);
    read_digit(2, e2, tag);
    read_digit(3, e3, tag);
  endtask

  initial begin
    int n;
    int idx;
    rst = 1'b1;
    load = 1'b0;
    bus = '0;
    signed_mode = 1'b0;
`ifdef OUTPUT_DISPLAY_HEX_EN
    hex_mode = 1'b0;
`endif
    #22;
    @(negedge clk);
    rst = 1'b0;
    check("rst_value", {24'd0, value}, 32'h00);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dig", {28'd0, dig}, 32'hE);
    check("rst_seg", {25'd0, seg}, {25'd0, S0});

    // Idle scan: first digit also covers the partial cycle after reset release.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      idx = ((k - 1) / 4) % 4;
      check($sformatf("scan_dig_k%0d", k), {28'd0, dig}, {28'd0, ~(4'd1 << idx)});
      check($sformatf("scan_seg_k%0d", k), {25'd0, seg}, {25'd0, (idx == 0) ? S0 : SB});
    end

    // 255 unsigned.
    do_load(8'hFF, 1'b0);
    busy_len(n);
    check("ff_busy_len", n, 32'd8);
    check("ff_value", {24'd0, value}, 32'hFF);
    check_display("ff", SB, S2, S5, S5);

    // -128 signed.
    do_load(8'h80, 1'b1);
    busy_len(n);
    check("m128_busy_len", n, 32'd8);
    check("m128_value", {24'd0, value}, 32'h80);
    check_display("m128", SM, S1, S2, S8);

    // Restart: 0x2A then 0x07 loaded on the third busy cycle.
    watch = 1'b1;
    @(negedge clk);
    load = 1'b1;
    bus = 8'h2A;
    signed_mode = 1'b0;
    @(negedge clk);
    load = 1'b0;
    check("rs_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    load = 1'b1;
    bus = 8'h07;
    @(negedge clk);
    load = 1'b0;
    busy_len(n);
    check("rs_busy_len", n, 32'd8);
    check("rs_value", {24'd0, value}, 32'h07);
    check_display("rs", SB, SB, SB, S7);
    watch = 1'b0;
    check("rs_no_42", seen4, 32'd0);

    // -1 signed, then 0 signed.
    do_load(8'hFF, 1'b1);
    busy_len(n);
    check("m1_busy_len", n, 32'd8);
    check_display("m1", SM, SB, SB, S1);
    do_load(8'h00, 1'b1);
    busy_len(n);
    check_display("zero", SB, SB, SB, S0);
    do_load(8'h05, 1'b1);
    busy_len(n);
    check_display("p5", SB, SB, SB, S5);

    // Mid-conversion asynchronous reset.
    do_load(8'h63, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_value", {24'd0, value}, 32'h00);
    check("mr_dig", {28'd0, dig}, 32'hE);
    check("mr_seg", {25'd0, seg}, {25'd0, S0});
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) @(negedge clk);
    check("mr_busy_after", {31'd0, busy}, 32'd0);
    check_display("mr", SB, SB, SB, S0);

`ifdef OUTPUT_DISPLAY_HEX_EN
    // Hex mode: raw nibbles, no conversion.
    @(negedge clk);
    load = 1'b1;
    bus = 8'hA5;
    signed_mode = 1'b0;
    hex_mode = 1'b1;
    @(negedge clk);
    load = 1'b0;
    hex_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hex_busy_%0d", k), {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    check("hex_value", {24'd0, value}, 32'hA5);
    check_display("hex", SB, SB, SA, S5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
